// File: rtl/tag_release_buffer.sv
// Commit-side queue of freed physical tags, presenting the two oldest to the freelist each cycle.
// Optional RELBUF_BYPASS_EN: tags arriving on an empty queue with hold=0 are released combinationally.
module tag_release_buffer #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] com_tag1,
    input  logic             com_tag1_val,
    input  logic [TAG_W-1:0] com_tag2,
    input  logic             com_tag2_val,
    input  logic             hold,
    output logic [TAG_W-1:0] released_tag1,
    output logic             released_tag1_val,
    output logic [TAG_W-1:0] released_tag2,
    output logic             released_tag2_val,
    output logic [1:0]       comnum,
    output logic             rel_full,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] tag1_p1, tag2_p1;
    logic             vld1_p1, vld2_p1;
    logic             rel_full_p1, overflow_p1;

    logic [1:0]       push_req, push_acc, pop;
    logic [TAG_W-1:0] push_tag0, push_tag1;
    logic [CNT_W-1:0] cnt_after_pop, free_after_pop, count_next;
    logic [PTR_W-1:0] rd_next;
    logic [TAG_W-1:0] tag1_p0, tag2_p0;
    logic             vld1_p0, vld2_p0;
    logic             bypass;

`ifdef RELBUF_BYPASS_EN
    assign bypass = (count == '0) && !hold;
`else
    assign bypass = 1'b0;
`endif

    // Stage 0: compact the push, retire what the freelist took, pick the next two oldest
    always_comb begin
        push_req  = {1'b0, com_tag1_val} + {1'b0, com_tag2_val};
        push_tag0 = com_tag1_val ? com_tag1 : com_tag2;
        push_tag1 = com_tag2;
        pop       = hold ? 2'd0 : ({1'b0, vld1_p1} + {1'b0, vld2_p1});

        cnt_after_pop  = count - CNT_W'(pop);
        free_after_pop = CNT_W'(DEPTH) - cnt_after_pop;
        if (bypass)
            push_acc = 2'd0;
        else if (free_after_pop >= CNT_W'(push_req))
            push_acc = push_req;
        else
            push_acc = free_after_pop[1:0];   // free < 2 here; youngest is dropped
        count_next = cnt_after_pop + CNT_W'(push_acc);
        rd_next    = rd_ptr + PTR_W'(pop);

        // Entries being written this edge are forwarded straight to the output slots
        if (cnt_after_pop != '0)
            tag1_p0 = mem[rd_next];
        else
            tag1_p0 = push_tag0;
        if (cnt_after_pop > CNT_W'(1))
            tag2_p0 = mem[rd_next + PTR_W'(1)];
        else if (cnt_after_pop == CNT_W'(1))
            tag2_p0 = push_tag0;
        else
            tag2_p0 = push_tag1;
        vld1_p0 = (count_next != '0);
        vld2_p0 = (count_next >= CNT_W'(2));
    end

    always_ff @(posedge clk) begin
        if (push_acc != 2'd0)
            mem[wr_ptr] <= push_tag0;
        if (push_acc == 2'd2)
            mem[wr_ptr + PTR_W'(1)] <= push_tag1;
    end

    // Stage 1: registered queue state and release outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tag1_p1     <= '0;
            tag2_p1     <= '0;
            vld1_p1     <= 1'b0;
            vld2_p1     <= 1'b0;
            rel_full_p1 <= 1'b0;
            overflow_p1 <= 1'b0;
        end else begin
            rd_ptr      <= rd_next;
            wr_ptr      <= wr_ptr + PTR_W'(push_acc);
            count       <= count_next;
            vld1_p1     <= vld1_p0;
            vld2_p1     <= vld2_p0;
            rel_full_p1 <= (CNT_W'(DEPTH) - count_next) < CNT_W'(2);
            if (push_acc != push_req && !bypass)
                overflow_p1 <= 1'b1;
            if (vld1_p0)
                tag1_p1 <= tag1_p0;
            if (vld2_p0)
                tag2_p1 <= tag2_p0;
        end
    end

`ifdef RELBUF_BYPASS_EN
    assign released_tag1     = bypass ? push_tag0 : tag1_p1;
    assign released_tag2     = bypass ? push_tag1 : tag2_p1;
    assign released_tag1_val = bypass ? (push_req != 2'd0) : vld1_p1;
    assign released_tag2_val = bypass ? (push_req == 2'd2) : vld2_p1;
`else
    assign released_tag1     = tag1_p1;
    assign released_tag2     = tag2_p1;
    assign released_tag1_val = vld1_p1;
    assign released_tag2_val = vld2_p1;
`endif
    assign comnum   = {1'b0, released_tag1_val} + {1'b0, released_tag2_val};
    assign rel_full = rel_full_p1;
    assign overflow = overflow_p1;
endmodule

// File: tb/tb_tag_release_buffer.sv
// Scoreboard bench for tag_release_buffer: expected tags queued at push, checked in release order.
module tb_tag_release_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] com_tag1, com_tag2;
    logic       com_tag1_val, com_tag2_val, hold;
    logic [5:0] released_tag1, released_tag2;
    logic       released_tag1_val, released_tag2_val;
    logic [1:0] comnum;
    logic       rel_full, overflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] sb[$];
    logic [5:0] exp_tag;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    tag_release_buffer #(.TAG_W(6), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .com_tag1(com_tag1), .com_tag1_val(com_tag1_val),
        .com_tag2(com_tag2), .com_tag2_val(com_tag2_val),
        .hold(hold),
        .released_tag1(released_tag1), .released_tag1_val(released_tag1_val),
        .released_tag2(released_tag2), .released_tag2_val(released_tag2_val),
        .comnum(comnum), .rel_full(rel_full), .overflow(overflow)
    );

    // Release monitor: every tag the freelist consumes must be the next expected one
    always @(negedge clk) begin
        if (mon_en && reset && !hold) begin
            n_tests++;
            if (released_tag2_val && !released_tag1_val) begin
                n_fail++;
                $display("FAIL val_pattern: got 01, required 1 or 11");
            end
            if (released_tag1_val) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_tag1: got %0d, required no release", released_tag1);
                end else begin
                    exp_tag = sb.pop_front();
                    if (released_tag1 !== exp_tag) begin
                        n_fail++;
                        $display("FAIL mon_tag1: got %0d, required %0d", released_tag1, exp_tag);
                    end
                end
            end
            if (released_tag2_val) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_tag2: got %0d, required no release", released_tag2);
                end else begin
                    exp_tag = sb.pop_front();
                    if (released_tag2 !== exp_tag) begin
                        n_fail++;
                        $display("FAIL mon_tag2: got %0d, required %0d", released_tag2, exp_tag);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [5:0] t1, input logic v2,
                         input logic [5:0] t2, input bit rec);
        com_tag1_val = v1; com_tag1 = t1;
        com_tag2_val = v2; com_tag2 = t2;
        if (rec && v1) sb.push_back(t1);
        if (rec && v2) sb.push_back(t2);
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        repeat (2) cyc();
        n_tests++;
        if ({released_tag1_val, released_tag2_val, comnum, rel_full, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v1=%b v2=%b comnum=%0d full=%b ovf=%b, required all 0",
                     released_tag1_val, released_tag2_val, comnum, rel_full, overflow);
        end
        reset = 1'b1;
        repeat (2) cyc();
        n_tests++;
        if (comnum !== 2'd0 || released_tag1_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got comnum=%0d, required 0", comnum);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_pair();
        drive(1'b1, 6'd5, 1'b1, 6'd9, 1'b1);
        cyc();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (released_tag1 !== 6'd5 || released_tag2 !== 6'd9 || comnum !== 2'd2) begin
            n_fail++;
            $display("FAIL pair_release: got %0d,%0d comnum=%0d, required 5,9 comnum=2",
                     released_tag1, released_tag2, comnum);
        end
        cyc();
        n_tests++;
        if (comnum !== 2'd0) begin
            n_fail++;
            $display("FAIL pair_drained: got comnum=%0d, required 0", comnum);
        end
    endtask

    task automatic test_tag2_only();
        drive(1'b0, 6'd0, 1'b1, 6'd7, 1'b1);
        cyc();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (released_tag1 !== 6'd7 || released_tag1_val !== 1'b1 ||
            released_tag2_val !== 1'b0 || comnum !== 2'd1) begin
            n_fail++;
            $display("FAIL tag2_only: got %0d v1=%b v2=%b comnum=%0d, required 7 1 0 1",
                     released_tag1, released_tag1_val, released_tag2_val, comnum);
        end
        cyc();
    endtask

    task automatic test_hold();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(2*i+1), 1'b1, 6'(2*i+2), 1'b1);
            cyc();
            n_tests++;
            if (released_tag1 !== 6'd1 || released_tag2 !== 6'd2 || comnum !== 2'd2) begin
                n_fail++;
                $display("FAIL hold_present: got %0d,%0d comnum=%0d, required 1,2 comnum=2",
                         released_tag1, released_tag2, comnum);
            end
        end
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        hold = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (comnum !== 2'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL hold_drain: got comnum=%0d pending=%0d, required 0 0", comnum, sb.size());
        end
    endtask

    task automatic test_overflow();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'(20+2*i), 1'b1, 6'(21+2*i), 1'b1);
            cyc();
            if (i == 5) begin
                n_tests++;
                if (rel_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: got rel_full=%b at 12 entries, required 0", rel_full);
                end
            end
        end
        n_tests++;
        if (rel_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_16: got rel_full=%b ovf=%b, required 1 0", rel_full, overflow);
        end
        drive(1'b1, 6'd60, 1'b1, 6'd61, 1'b0);
        cyc();
        n_tests++;
        if (overflow !== 1'b1 || released_tag1 !== 6'd20 || comnum !== 2'd2) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b tag1=%0d comnum=%0d, required 1 20 2",
                     overflow, released_tag1, comnum);
        end
        hold = 1'b0;
        drive(1'b1, 6'd62, 1'b1, 6'd63, 1'b1);
        cyc();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (rel_full !== 1'b1 || overflow !== 1'b1 || released_tag1 !== 6'd22) begin
            n_fail++;
            $display("FAIL full_pushpop: got rel_full=%b ovf=%b tag1=%0d, required 1 1 22",
                     rel_full, overflow, released_tag1);
        end
        repeat (9) cyc();
        n_tests++;
        if (comnum !== 2'd0 || sb.size() != 0 || overflow !== 1'b1 || rel_full !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain: got comnum=%0d pending=%0d ovf=%b full=%b, required 0 0 1 0",
                     comnum, sb.size(), overflow, rel_full);
        end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(40+2*i), 1'b1, 6'(41+2*i), 1'b1);
            cyc();
        end
        hold = 1'b0;
        drive(1'b1, 6'd50, 1'b1, 6'd51, 1'b1);
        cyc();
        mon_en = 1'b0;
        reset  = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        #1;
        n_tests++;
        if ({released_tag1_val, released_tag2_val, comnum, rel_full, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got v1=%b v2=%b comnum=%0d full=%b ovf=%b, required all 0",
                     released_tag1_val, released_tag2_val, comnum, rel_full, overflow);
        end
        sb.delete();
        cyc();
        reset  = 1'b1;
        mon_en = 1'b1;
        drive(1'b1, 6'd30, 1'b1, 6'd31, 1'b1);
        cyc();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        repeat (2) cyc();
        n_tests++;
        if (comnum !== 2'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_after: got comnum=%0d pending=%0d, required 0 0", comnum, sb.size());
        end
    endtask

`ifdef RELBUF_BYPASS_EN
    task automatic test_bypass();
        hold = 1'b0;
        drive(1'b1, 6'd10, 1'b1, 6'd11, 1'b1);
        #1;
        n_tests++;
        if (released_tag1 !== 6'd10 || released_tag2 !== 6'd11 || comnum !== 2'd2) begin
            n_fail++;
            $display("FAIL bypass_same: got %0d,%0d comnum=%0d, required 10,11 comnum=2",
                     released_tag1, released_tag2, comnum);
        end
        cyc();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        #1;
        n_tests++;
        if (comnum !== 2'd0 || released_tag1_val !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_noenq: got comnum=%0d, required 0", comnum);
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
`ifdef RELBUF_BYPASS_EN
        test_bypass();
`else
        test_pair();
        test_tag2_only();
`endif
        test_hold();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
